// File: rtl/jrca_scheduler.sv
// Round-robin sequencer for a shared external 4-bit ripple-carry adder.
// Two requesters; one nibble per cycle, LSB first, carry chained in a register.
module jrca_scheduler #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic [1:0]   ack,
  output logic         busy,
  output logic         valid,
  output logic         id,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_y,
  input  logic         add_cout
);

  localparam int KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic           r_cr;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic           r_id;
  logic           r_last;
  logic [KW-1:0]  r_k;
  logic           r_busy;
  logic           r_valid;
  logic [1:0]     r_ack;

  logic           w_win;
  logic           w_run;
  logic [W-1:0]   w_opa_nxt;

  // Tie goes to whoever was not served last.
  assign w_win = (req == 2'b11) ? ~r_last : req[1];
  assign w_run = (r_state == RUN);
  // Result nibbles are shifted into the vacated top of the A register.
  assign w_opa_nxt = {add_y, r_opa[W-1:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_cr    <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ack   <= 2'b00;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          r_ack   <= 2'b00;
          if (|req) begin
            r_opa   <= w_win ? a1 : a0;
            r_opb   <= w_win ? b1 : b0;
            r_cr    <= w_win ? cin1 : cin0;
            r_id    <= w_win;
            r_last  <= w_win;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_opa <= w_opa_nxt;
          r_opb <= {4'd0, r_opb[W-1:4]};
          r_cr  <= add_cout;
          r_k   <= r_k + 1'b1;
          if (r_k == KW'(NIBBLES - 1)) begin
            r_sum   <= w_opa_nxt;
            r_cout  <= add_cout;
            r_valid <= 1'b1;
            r_ack   <= r_id ? 2'b10 : 2'b01;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_ack   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign add_a   = w_run ? r_opa[3:0] : 4'd0;
  assign add_b   = w_run ? r_opb[3:0] : 4'd0;
  assign add_cin = w_run ? r_cr : 1'b0;

  assign ack   = r_ack;
  assign busy  = r_busy;
  assign valid = r_valid;
  assign id    = r_id;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_jrca_scheduler.sv
// Scoreboard bench for jrca_scheduler with a behavioural 4-bit adder.
// Driver pushes expected results; a negedge monitor pops on valid.
module tb_jrca_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        cin0 = 1'b0, cin1 = 1'b0;
  logic [1:0]  ack;
  logic        busy, valid, id, cout;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_y;
  logic        add_cin, add_cout;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  exp_t sbq[$];

  jrca_scheduler #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .cin0(cin0),
    .a1(a1), .b1(b1), .cin1(cin1),
    .ack(ack), .busy(busy), .valid(valid), .id(id),
    .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_y(add_y), .add_cout(add_cout)
  );

  // External ripple-carry slice.
  assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
        chk("id", {31'd0, id}, {31'd0, e.id});
        chk("ack", {30'd0, ack}, e.id ? 32'd2 : 32'd1);
      end
    end else if (ack != 2'b00) begin
      chk("ack_without_valid", {30'd0, ack}, 32'd0);
    end
  end

  task automatic issue(input logic [1:0] rq, input logic eid,
                       input logic [15:0] esum, input logic ecout,
                       input bit seq, input logic [15:0] esa,
                       input logic [15:0] esb, input logic [3:0] esc,
                       input bit chg);
    logic [15:0] sa, sb;
    logic [3:0]  sc;
    int n;
    exp_t e;
    e.id = eid; e.sum = esum; e.cout = ecout;
    sbq.push_back(e);
    req = rq;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      chk("grant_timeout", {31'd0, busy}, 32'd1);
      void'(sbq.pop_back());
      req = 2'b00;
      return;
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sa[4*i +: 4] = add_a;
      sb[4*i +: 4] = add_b;
      sc[i] = add_cin;
      if (i == 0 && chg) a0 = 16'h0000;
      @(negedge clk);
    end
    if (seq) begin
      chk("add_a_seq", {16'd0, sa}, {16'd0, esa});
      chk("add_b_seq", {16'd0, sb}, {16'd0, esb});
      chk("add_cin_seq", {28'd0, sc}, {28'd0, esc});
    end
    chk("valid_cycle5", {31'd0, valid}, 32'd1);
    @(negedge clk);
    chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nv;
    #1;
    chk("reset_outs",
        {7'd0, ack, busy, valid, id, sum, cout, add_a, add_cin},
        32'd0);
    chk("reset_add_b", {28'd0, add_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
    issue(2'b01, 1'b0, 16'h5555, 1'b0, 1'b1,
          16'h1234, 16'h4321, 4'b0000, 1'b0);

    a0 = 16'hFFFF; b0 = 16'h0001; cin0 = 1'b0;
    issue(2'b01, 1'b0, 16'h0000, 1'b1, 1'b1,
          16'hFFFF, 16'h0001, 4'b1110, 1'b0);

    a1 = 16'hFFFF; b1 = 16'hFFFF; cin1 = 1'b1;
    issue(2'b10, 1'b1, 16'hFFFF, 1'b1, 1'b0,
          16'h0, 16'h0, 4'h0, 1'b0);

    a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
    issue(2'b01, 1'b0, 16'h5555, 1'b0, 1'b0,
          16'h0, 16'h0, 4'h0, 1'b1);

    // Reset abort during RUN cycle 2.
    a0 = 16'h1234; b0 = 16'h4321;
    req = 2'b01;
    nv = 0;
    while (!busy && nv < 20) begin
      @(negedge clk);
      nv++;
    end
    chk("abort_grant", {31'd0, busy}, 32'd1);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_outs",
        {7'd0, ack, busy, valid, id, sum, cout, add_a, add_cin},
        32'd0);
    chk("abort_add_b", {28'd0, add_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
    a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b1;
    issue(2'b11, 1'b0, 16'h3333, 1'b0, 1'b0,
          16'h0, 16'h0, 4'h0, 1'b0);

    // Continuous contention from reset.
    reset = 1'b1;
    req = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.id = i[0];
      e.sum = i[0] ? 16'h0001 : 16'h3333;
      e.cout = i[0];
      sbq.push_back(e);
    end
    nv = 0;
    for (int c = 0; c < 60 && nv < 4; c++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        if (nv == 4) begin
          req = 2'b00;
        end else begin
          @(negedge clk);
          chk("gap_busy_lo", {31'd0, busy}, 32'd0);
          chk("ack_one_cycle", {30'd0, ack}, 32'd0);
          @(negedge clk);
          chk("gap_busy_hi", {31'd0, busy}, 32'd1);
        end
      end
    end
    chk("contention_count", nv, 32'd4);
    req = 2'b00;

    nv = 0;
    while (sbq.size() != 0 && nv < 50) begin
      @(negedge clk);
      nv++;
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jrca_scheduler.md
# jrca_scheduler

Sequencer and arbiter for the shared 4-bit ripple-carry adder. Two requesters submit NIBBLES×4-bit additions. The block grants one requester round-robin, latches its operands and drives the external 4-bit adder one nibble per cycle, least-significant nibble first, chaining the carry through a register. It returns the wide sum and carry-out with a one-cycle valid/ack.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (NIBBLES ≥ 2)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  2  level request per requester (bit i = requester i)
- a0, b0  in  W  requester 0 operands
- cin0  in  1  requester 0 carry-in
- a1, b1  in  W  requester 1 operands
- cin1  in  1  requester 1 carry-in
- ack  out  2  one-cycle pulse to the served requester, coincident with valid
- busy  out  1  high from grant until the cycle after valid
- valid  out  1  one-cycle pulse: sum/cout/id hold a completed result
- id  out  1  requester served by the current/last operation
- sum  out  W  wide result, held until next operation completes
- cout  out  1  final carry-out, held with sum
- add_a, add_b  out  4  nibble operands to the external adder
- add_cin  out  1  carry into the external adder
- add_y  in  4  adder sum (combinational, same cycle)
- add_cout  in  1  adder carry-out

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE: if any req bit is high, grant one requester.
  - Both high: grant the requester not in last_id.
  - last_id resets to 1, so requester 0 wins the first tie.
- On grant:
  - latch a/b into shift registers opa/opb and cin into carry register cr;
  - id ← winner, last_id ← winner, slice counter k ← 0, busy ← 1, go RUN.
- RUN, slice k:
  - drive add_a = opa[3:0], add_b = opb[3:0], add_cin = cr;
  - at the clock edge: sum register shifts right 4 with add_y entering bits [W-1:W-4]; cr ← add_cout; opa/opb shift right 4; k ← k+1.
  - After slice NIBBLES-1, go DONE.
- DONE, one cycle:
  - valid = 1, ack[id] = 1, cout = cr, sum is complete.
  - Next state IDLE; busy drops at the DONE→IDLE edge.
- Outside RUN, add_a, add_b and add_cin are 0.
- Operands are sampled only at grant. Input changes after grant do not affect the running operation.
- req is sampled only in IDLE. A requester still requesting after its ack is re-arbitrated normally, so alternation holds under continuous contention.
- A request withdrawn before grant is never served and produces no ack.
- Arithmetic is unsigned modulo 2^W, with the overflow carry in cout. sum = (a + b + cin) mod 2^W; cout = bit W of the full sum.
- Reset mid-operation:
  - aborts with no ack or valid;
  - outputs return to reset values;
  - last_id returns to 1.

## Timing
- Reset values: ack=0, busy=0, valid=0, id=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0.
- Grant edge = cycle 0.
- RUN occupies cycles 1..NIBBLES; slice k is driven in cycle k+1.
- valid and ack are high in cycle NIBBLES+1 (cycle 5 for NIBBLES=4).
- Earliest next grant is at the end of cycle NIBBLES+2. Throughput is one operation per NIBBLES+2 cycles.
- The adder path is combinational within one cycle. add_y/add_cout must settle before the capturing edge; they are not registered outside the block.
- sum/cout change only at the edge entering DONE (sum shifts during RUN internally; the exported sum may be the shift register itself, stable from DONE onward).
- No output is combinationally dependent on req or operand inputs.

## Test plan
- req=01, a0=16'h1234, b0=16'h4321, cin0=0:
  - add_a sequence 4,3,2,1 and add_b sequence 1,2,3,4;
  - valid/ack=01 in cycle 5; sum=16'h5555, cout=0, id=0.
- req=01, a0=16'hFFFF, b0=16'h0001, cin0=0:
  - carry propagates through all slices;
  - sum=16'h0000, cout=1; add_cin sequence 0,1,1,1.
- req=10, a1=16'hFFFF, b1=16'hFFFF, cin1=1 → sum=16'hFFFF, cout=1, ack=10, id=1.
- req=11 held continuously from reset, both requesters with distinct operands:
  - service order 0,1,0,1;
  - each ack one cycle wide; busy low for exactly one cycle between operations.
- reset asserted during RUN (cycle 2) for one cycle:
  - valid/ack never pulse and all outputs are 0 immediately;
  - then req=11 → requester 0 granted first.
- Operand change after grant (a0 switched to 16'h0000 in cycle 1 of a 16'h1234 + 16'h4321 operation) → sum still 16'h5555.
